// File: rtl/scan_decoder.sv
// One-hot decoder with direct select or auto-scan (prescaled index walk); optional scan via SCAN_DECODER_SCAN_EN.
// Latency: 1 cycle from sel/en/mode sampling to y/idx/wrap, all outputs decoded from registers only.
// Backpressure: none; en=0 parks the block in IDLE with position held.
module scan_decoder #(
   parameter int SEL_W = 3,
   parameter int DIV_W = 4,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic [OUT_W-1:0] y,
   output logic [SEL_W-1:0] idx,
   output logic             wrap
);

`ifdef SCAN_DECODER_SCAN_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1
   } state_e;
`endif

   state_e           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;

   // The next state is decoded straight from the inputs, so the datapath acts on
   // the mode being entered; this gives DIRECT its single-cycle select latency.
   always_comb begin
      state_d = IDLE;
      if (en) begin
`ifdef SCAN_DECODER_SCAN_EN
         state_d = mode ? SCAN : DIRECT;
`else
         state_d = DIRECT;
`endif
      end
   end

`ifdef SCAN_DECODER_SCAN_EN
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;

   // ">=" rather than "==" so a div lowered below the running count ends the
   // dwell on the next cycle instead of counting round the full prescaler range.
   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      case (state_d)
         DIRECT: begin
            idx_d = sel;
            cnt_d = '0;
         end
         SCAN: begin
            if (load) begin
               idx_d = sel;
               cnt_d = '0;
            end else if (cnt_q >= div) begin
               cnt_d  = '0;
               idx_d  = idx_q + SEL_W'(1);
               wrap_d = (idx_q == '1);
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   assign wrap = wrap_q;
`else
   logic unused_scan_inputs;
   assign unused_scan_inputs = ^{mode, load, div};

   always_comb begin
      idx_d = idx_q;
      case (state_d)
         DIRECT:  idx_d = sel;
         default: idx_d = idx_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   assign wrap = 1'b0;
`endif

   assign y   = (state_q == IDLE) ? '0 : (OUT_W'(1) << idx_q);
   assign idx = idx_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: expectations queued at drive time, checked one cycle later.
module tb_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n, en, mode, load;
   logic [2:0]  sel;
   logic [3:0]  sel16;
   logic [3:0]  div;
   logic [7:0]  y;
   logic [2:0]  idx;
   logic        wrap;
   logic [15:0] y16;
   logic [3:0]  idx16;
   logic        wrap16;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [15:0] y;
      logic [3:0]  idx;
      logic        wrap;
      bit          wide;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   scan_decoder #(.SEL_W(3), .DIV_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
      .load(load), .div(div), .y(y), .idx(idx), .wrap(wrap)
   );

   scan_decoder #(.SEL_W(4), .DIV_W(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel16),
      .load(load), .div(div), .y(y16), .idx(idx16), .wrap(wrap16)
   );

   task automatic push_exp(input string tag, input logic [15:0] ey, input logic [3:0] ei,
                           input logic ew, input bit wide);
      exp_t e;
      e.tag  = tag;
      e.y    = ey;
      e.idx  = ei;
      e.wrap = ew;
      e.wide = wide;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t        e;
      logic [15:0] oy;
      logic [3:0]  oi;
      logic        ow;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty observed 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      if (e.wide) begin
         oy = y16;
         oi = idx16;
         ow = wrap16;
      end else begin
         oy = {8'h00, y};
         oi = {1'b0, idx};
         ow = wrap;
      end
      n_assert++;
      assert (oy === e.y) else begin
         n_fail++;
         $error("FAIL %s y observed %h expected %h", e.tag, oy, e.y);
      end
      n_assert++;
      assert (oi === e.idx) else begin
         n_fail++;
         $error("FAIL %s idx observed %0d expected %0d", e.tag, oi, e.idx);
      end
      n_assert++;
      assert (ow === e.wrap) else begin
         n_fail++;
         $error("FAIL %s wrap observed %b expected %b", e.tag, ow, e.wrap);
      end
   endtask

   task automatic step(input bit s_en, input bit s_mode, input logic [2:0] s_sel,
                       input bit s_load, input logic [3:0] s_div, input string tag,
                       input logic [7:0] ey, input logic [2:0] ei, input logic ew);
      @(negedge clk);
      en   = s_en;
      mode = s_mode;
      sel  = s_sel;
      load = s_load;
      div  = s_div;
      push_exp(tag, {8'h00, ey}, {1'b0, ei}, ew, 1'b0);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   task automatic step16(input bit s_mode, input logic [3:0] s_sel, input bit s_load,
                         input logic [3:0] s_div, input string tag,
                         input logic [15:0] ey, input logic [3:0] ei, input logic ew);
      @(negedge clk);
      en    = 1'b1;
      mode  = s_mode;
      sel16 = s_sel;
      load  = s_load;
      div   = s_div;
      push_exp(tag, ey, ei, ew, 1'b1);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   task automatic async_reset_check(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      push_exp(tag, 16'h0000, 4'd0, 1'b0, 1'b0);
      check_pop();
      push_exp({tag, "_w"}, 16'h0000, 4'd0, 1'b0, 1'b1);
      check_pop();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      mode  = 1'b0;
      load  = 1'b0;
      sel   = 3'd0;
      sel16 = 4'd0;
      div   = 4'd0;
      #2;
      push_exp("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
      check_pop();
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 8; k++)
         step(1, 0, 3'(k), 0, 0, "direct_sweep", 8'(1 << k), 3'(k), 1'b0);

`ifdef SCAN_DECODER_SCAN_EN
      step(1, 0, 3'd0, 0, 2, "dwell_pre", 8'h01, 3'd0, 1'b0);
      for (int c = 1; c <= 25; c++) begin
         int k;
         k = (c / 3) % 8;
         step(1, 1, 3'd0, 0, 2, "dwell", 8'(1 << k), 3'(k), (c % 24) == 0);
      end

      step(1, 0, 3'd2, 0, 0, "lp_pre",   8'h04, 3'd2, 1'b0);
      step(1, 1, 3'd5, 1, 0, "lp_load",  8'h20, 3'd5, 1'b0);
      step(1, 1, 3'd0, 0, 0, "lp_adv6",  8'h40, 3'd6, 1'b0);
      step(1, 1, 3'd0, 0, 0, "lp_adv7",  8'h80, 3'd7, 1'b0);
      step(1, 1, 3'd0, 0, 0, "lp_wrap",  8'h01, 3'd0, 1'b1);
      step(1, 1, 3'd0, 0, 0, "lp_after", 8'h02, 3'd1, 1'b0);
      step(1, 0, 3'd7, 0, 0, "lp7_pre",  8'h80, 3'd7, 1'b0);
      step(1, 1, 3'd3, 1, 0, "lp7_load", 8'h08, 3'd3, 1'b0);

      step(1, 0, 3'd4, 0, 3, "g_pre", 8'h10, 3'd4, 1'b0);
      step(1, 1, 3'd0, 0, 3, "g_d1",  8'h10, 3'd4, 1'b0);
      step(1, 1, 3'd0, 0, 3, "g_d2",  8'h10, 3'd4, 1'b0);
      for (int i = 0; i < 3; i++)
         step(0, 1, 3'd7, 1, 3, "g_idle", 8'h00, 3'd4, 1'b0);
      step(1, 1, 3'd0, 0, 3, "g_resume", 8'h10, 3'd4, 1'b0);
      step(1, 1, 3'd0, 0, 3, "g_adv",    8'h20, 3'd5, 1'b0);

      step(1, 1, 3'd0, 0, 3, "dc_c1",   8'h20, 3'd5, 1'b0);
      step(1, 1, 3'd0, 0, 3, "dc_c2",   8'h20, 3'd5, 1'b0);
      step(1, 1, 3'd0, 0, 1, "dc_over", 8'h40, 3'd6, 1'b0);
      step(1, 1, 3'd0, 0, 1, "dc_hold", 8'h40, 3'd6, 1'b0);
      async_reset_check("async_rst");
      step(1, 0, 3'd3, 0, 0, "post_rst", 8'h08, 3'd3, 1'b0);

      step16(0, 4'd14, 0, 0, "w16_pre",  16'h4000, 4'd14, 1'b0);
      step16(1, 4'd0,  0, 0, "w16_15",   16'h8000, 4'd15, 1'b0);
      step16(1, 4'd0,  0, 0, "w16_wrap", 16'h0001, 4'd0,  1'b1);
      step16(1, 4'd0,  0, 0, "w16_1",    16'h0002, 4'd1,  1'b0);
`else
      step(1, 1, 3'd5, 1, 0, "m1_direct", 8'h20, 3'd5, 1'b0);
      step(1, 1, 3'd2, 1, 0, "m1_direct", 8'h04, 3'd2, 1'b0);
      step(1, 1, 3'd7, 0, 3, "m1_direct", 8'h80, 3'd7, 1'b0);

      step(1, 0, 3'd4, 0, 0, "g_pre", 8'h10, 3'd4, 1'b0);
      for (int i = 0; i < 3; i++)
         step(0, 0, 3'd1, 0, 0, "g_idle", 8'h00, 3'd4, 1'b0);
      step(1, 1, 3'd1, 0, 0, "g_resume", 8'h02, 3'd1, 1'b0);

      step(1, 0, 3'd6, 0, 0, "rst_pre", 8'h40, 3'd6, 1'b0);
      async_reset_check("async_rst");
      step(1, 0, 3'd3, 0, 0, "post_rst", 8'h08, 3'd3, 1'b0);

      step16(1, 4'd13, 1, 0, "w16_m1", 16'h2000, 4'd13, 1'b0);
      step16(1, 4'd14, 0, 0, "w16_m1", 16'h4000, 4'd14, 1'b0);
      step16(1, 4'd15, 0, 0, "w16_m1", 16'h8000, 4'd15, 1'b0);
      step16(1, 4'd0,  0, 0, "w16_m1", 16'h0001, 4'd0,  1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
